// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the default baud divider for a 100 MHz clock at 9600 baud.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Oversample ticks per bit, and the tick index at the middle of the start bit
  localparam int unsigned OVERSAMPLE       = 16;
  localparam int unsigned MID_START        = 7;
  localparam int unsigned DEFAULT_BAUD_DIV = 651;

endpackage

// File: rtl/baud_rate_generator.sv
// Free-running oversample tick generator: one-cycle tick every BAUD_DIV clocks.
// Shared between the receive and (future) transmit sides.
module baud_rate_generator
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrap at BAUD_DIV-1; never realigned to frame boundaries
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling. Feeds the write side of the RX FIFO
// and reports framing / overrun errors as single-cycle pulses.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned BAUD_DIV   = DEFAULT_BAUD_DIV
`ifdef UART_RX_PARITY_EN
  , parameter bit        PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 fifo_full,
  output logic [DATA_SIZE-1:0] rx_data_out,
  output logic                 rx_done_tick,
  output logic                 frame_err,
  output logic                 overrun_err
`ifdef UART_RX_PARITY_EN
  , output logic               parity_err
`endif
);

  localparam int unsigned NW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [4:0]    S_MID  = 5'(MID_START);
  localparam logic [4:0]    S_BIT  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]    S_STOP = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_SIZE - 1);

  logic                 tick;
  logic                 rx_meta_q, rx_s_q;
  rx_state_e            state_q;
  logic [4:0]           s_q;
  logic [NW-1:0]        n_q;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [DATA_SIZE-1:0] data_q;
  logic                 done_q, ferr_q, ovr_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q;
  logic                 perr_q;
  logic                 par_bad;
`endif

  baud_rate_generator #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchronizer; idles high so reset does not look like a start edge
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Line order is LSB first, so new bits enter at the MSB and shift right
  always_comb begin
    shift_d = {rx_s_q, shift_q[DATA_SIZE-1:1]};
  end

`ifdef UART_RX_PARITY_EN
  // Received parity bit must make the total XOR equal the selected sense
  always_comb begin
    par_bad = ((^shift_q) ^ par_bit_q) != PARITY_ODD;
  end
`endif

  // Receive FSM; all outputs are registered one-cycle pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      n_q       <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_q <= ST_START;
            s_q     <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (s_q == S_MID) begin
              if (rx_s_q) begin
                state_q <= ST_IDLE;      // glitch, not a real start bit
              end else begin
                state_q <= ST_DATA;
                s_q     <= '0;
                n_q     <= '0;
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (s_q == S_BIT) begin
              s_q     <= '0;
              shift_q <= shift_d;
              if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_STOP;
`endif
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            if (s_q == S_BIT) begin
              s_q       <= '0;
              par_bit_q <= rx_s_q;
              state_q   <= ST_STOP;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (s_q == S_STOP) begin
              state_q <= ST_IDLE;
              s_q     <= '0;
              if (!rx_s_q) begin
                ferr_q <= 1'b1;          // framing error wins over parity
`ifdef UART_RX_PARITY_EN
              end else if (par_bad) begin
                perr_q <= 1'b1;
`endif
              end else begin
                data_q <= shift_q;
                done_q <= 1'b1;
                ovr_q  <= fifo_full;     // FIFO will drop this word
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data_out  = data_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign overrun_err  = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that deserialises an asynchronous UART line into parallel words and drives the write side of the receive FIFO. It sits directly upstream of `fifo`:
- `rx_done_tick` connects to `write_to_fifo`.
- `rx_data_out` connects to `write_data_in`.
- The FIFO's `full` connects back to `fifo_full`.

It uses 16x oversampling from an internal baud tick and reports framing and overrun errors as single-cycle pulses.

## Interface
- `DATA_SIZE`, 8, data bits per frame; must match the FIFO `DATA_SIZE`.
- `SB_TICK`, 16, oversample ticks in the stop bit (16 = 1 stop bit, 32 = 2 stop bits).
- `BAUD_DIV`, 651, `clk` cycles per oversample tick (100 MHz / (9600 × 16)); must be ≥ 2.
- `clk`  in  1  system clock. One clock domain only.
- `reset`  in  1  synchronous, active-high.
- `rx`  in  1  asynchronous serial line; idles high.
- `fifo_full`  in  1  FIFO `full` flag.
- `rx_data_out`  out  `DATA_SIZE`  last received word; held stable until the next frame completes.
- `rx_done_tick`  out  1  one-cycle pulse when a valid word is in `rx_data_out`.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun_err`  out  1  one-cycle pulse when `rx_done_tick` fires while `fifo_full` = 1.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1. All decisions below use the synchronized `rx_s`.
- Tick counter: 0 … `BAUD_DIV`−1. `tick` is high for one cycle when the count equals `BAUD_DIV`−1. The counter runs freely and is not realigned to frames.
- FSM states:
  - **IDLE**: on `rx_s` = 0, go to START and set s = 0.
  - **START**: on each tick, s++. When s = 7 (middle of the start bit):
    - if `rx_s` = 1, false start; go to IDLE;
    - otherwise go to DATA with s = 0 and n = 0.
  - **DATA**: on each tick, s++. When s = 15, sample `rx_s` into the shift register MSB and shift right (LSB-first line order), set s = 0, n++. After sample n = `DATA_SIZE`−1, go to STOP.
  - **STOP**: on each tick, s++. When s = `SB_TICK`−1, sample `rx_s`:
    - if 1, load `rx_data_out` from the shift register and pulse `rx_done_tick`;
    - if 0, pulse `frame_err`; `rx_data_out` is unchanged and there is no `rx_done_tick`;
    - in both cases go to IDLE.
- `overrun_err` equals `rx_done_tick` AND `fifo_full`, registered into the same cycle as `rx_done_tick`. The FIFO drops the word; this block takes no other action.
- Widths:
  - s: 5 bits (covers `SB_TICK` up to 32);
  - n: clog2(`DATA_SIZE`) bits;
  - tick counter: clog2(`BAUD_DIV`) bits.
- If `rx` stays low (break condition): the frame ends with `frame_err`, then the FSM re-enters START on the next cycle while `rx_s` is still 0. Expect repeated `frame_err` pulses, and no `rx_done_tick`, for as long as the break lasts.

## Timing
- Reset values:
  - `rx_data_out` = 0, `rx_done_tick` = 0, `frame_err` = 0, `overrun_err` = 0;
  - state = IDLE, s = n = 0, tick counter = 0, sync flops = 1.
- Reset mid-frame aborts the frame: no pulses and no change to `rx_data_out` after reset is released.
- Start-edge detect latency: 2 cycles (synchronizer) plus 1 cycle (IDLE→START).
- Frame completion: `rx_done_tick` or `frame_err` occurs 8 + 16·`DATA_SIZE` + `SB_TICK` ticks after START entry, ±1 tick of phase.
- `rx_data_out` is valid in the same cycle as `rx_done_tick`. The FIFO captures it on that clock edge.
- Outputs never pulse for more than 1 cycle. Consecutive `rx_done_tick` pulses are at least one frame apart.

## Configuration
- `UART_RX_PARITY_EN`:
  - **Defined**: a PARITY state sits between DATA and STOP and samples one extra bit at s = 15. A port `parity_err` (out, 1) is added, plus a parameter `PARITY_ODD` (default 0 = even parity). On mismatch, `parity_err` pulses at the STOP decision cycle and `rx_done_tick` is suppressed. `frame_err` takes priority if both errors occur.
  - **Not defined**: there is no PARITY state and no `parity_err` port, and the frame is 1 + `DATA_SIZE` + stop bits.

## Structure
- Shared package `uart_pkg`:
  - the state encoding typedef (IDLE, START, DATA, PARITY, STOP);
  - the oversample constant 16 and the mid-start count 7;
  - the default `BAUD_DIV` constant.
- One sub-module, `baud_rate_generator`: parameter `BAUD_DIV`, ports `clk`, `reset`, `tick`. It will be reused by the future `uart_tx` on the FIFO read side.

## Test plan
All scenarios use `BAUD_DIV` = 4 for simulation speed.
- Send 0xA5 (8N1) → a single `rx_done_tick`, `rx_data_out` = 0xA5, `frame_err` = 0.
- Send 0x01 then 0xFF back to back → two `rx_done_tick` pulses, with values 0x01 then 0xFF in order; the FIFO holds both.
- Drive a 5-tick low glitch on idle `rx` → the FSM returns to IDLE with no pulses.
- Send 0x3C with the stop bit forced low → `frame_err` pulses once, no `rx_done_tick`, `rx_data_out` keeps its previous value.
- Send 0x55 with `fifo_full` = 1 → `rx_done_tick` and `overrun_err` pulse in the same cycle.
- Assert `reset` during data bit 4 of 0x96, release it, then send 0x42 → no output for 0x96; `rx_data_out` = 0x42. With `UART_RX_PARITY_EN`: send 0x42 with wrong parity → `parity_err` pulses and there is no `rx_done_tick`.
